serializer: RTL and testbench



---
 rtl/serializer.sv | 68 ++++++
 tb/tb_serializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// serializer: parallel-to-serial converter, emits N bits of a DATA_W word MSB-first, one per clock
// Ports:
//   clk_i          rising-edge clock
//   arst_i         asynchronous active-high reset
//   data_i         parallel word, bit DATA_W-1 sent first
//   data_mod_i     number of bits to send from the MSB, 0 means all DATA_W bits
//   data_val_i     request strobe, accepted when busy_o is low
//   ser_data_o     serial bit, 0 whenever ser_data_val_o is low
//   ser_data_val_o ser_data_o is valid this cycle
//   busy_o         a request presented now would be ignored
module serializer #(
  parameter  int DATA_W = 16,
  localparam int MOD_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);
  localparam int CNT_W = MOD_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  n;
  logic              accept;
  // a count above DATA_W (only possible for non-power-of-two widths) is clamped to a full word
  always_comb begin
    n      = (data_mod_i == '0 || {1'b0, data_mod_i} > FULL) ? FULL : {1'b0, data_mod_i};
    accept = data_val_i && !busy_o;
  end
  // cnt holds the bits still to be shown, including the one currently on ser_data_o;
  // busy_o drops when the next cycle will be the last bit so a reload can follow without a gap
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      state          <= IDLE;
      shreg          <= '0;
      cnt            <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else if (accept) begin
      state          <= SHIFT;
      shreg          <= data_i << 1;
      cnt            <= n;
      ser_data_o     <= data_i[DATA_W-1];
      ser_data_val_o <= 1'b1;
      busy_o         <= n != CNT_W'(1);
    end else if (state == SHIFT && cnt != CNT_W'(1)) begin
      shreg          <= shreg << 1;
      cnt            <= cnt - 1'b1;
      ser_data_o     <= shreg[DATA_W-1];
      ser_data_val_o <= 1'b1;
      busy_o         <= cnt != CNT_W'(2);
    end else begin
      state          <= IDLE;
      shreg          <= '0;
      cnt            <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed self-checking bench for serializer
module tb_serializer;
  logic        clk = 1'b0;
  logic        arst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic [3:0]  data_mod_i = '0;
  logic        data_val_i = 1'b0;
  logic        ser_data_o, ser_data_val_o, busy_o;
  int          total = 0;
  int          bad = 0;
  logic        lb_on = 1'b0;
  logic [15:0] rx_sr = '0;
  int          rx_cnt = 0;
  logic [15:0] rx_q[$];
  logic [15:0] tx_q[$];

  serializer #(.DATA_W(16)) dut (
    .clk_i(clk), .arst_i(arst_i), .data_i(data_i), .data_mod_i(data_mod_i),
    .data_val_i(data_val_i), .ser_data_o(ser_data_o), .ser_data_val_o(ser_data_val_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // acts as the deserializer: packs every 16 valid bits MSB-first into a word
  always @(negedge clk)
    if (lb_on && ser_data_val_o) begin
      rx_sr = {rx_sr[14:0], ser_data_o};
      rx_cnt++;
      if (rx_cnt == 16) begin
        rx_q.push_back(rx_sr);
        rx_cnt = 0;
      end
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_val"}, 32'(ser_data_val_o), 0);
    chk({tag, "_dat"}, 32'(ser_data_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
  endtask

  // call at a negedge while idle; checks every bit and the idle cycle after
  task automatic xfer(input logic [15:0] d, input logic [3:0] m, input string tag);
    int n;
    n = (m == 0) ? 16 : int'(m);
    data_i = d;
    data_mod_i = m;
    data_val_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      data_val_i = 1'b0;
      chk($sformatf("%s_val%0d", tag, k), 32'(ser_data_val_o), 1);
      chk($sformatf("%s_dat%0d", tag, k), 32'(ser_data_o), 32'(d[15-k]));
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy_o), 32'(k != n - 1));
    end
    @(negedge clk);
    idle_chk({tag, "_end"});
  endtask

  initial begin
    logic [31:0] pair;
    int t;
    @(negedge clk);
    idle_chk("rst");
    @(negedge clk);
    arst_i = 1'b0;
    @(negedge clk);
    idle_chk("post_rst");

    xfer(16'hA5C3, 4'd0, "full");
    @(negedge clk);
    idle_chk("full_after");

    xfer(16'hF000, 4'd3, "part3");
    @(negedge clk);
    idle_chk("part3_after");
    xfer(16'h7FFF, 4'd1, "one0");
    xfer(16'h8000, 4'd1, "one1");

    pair = 32'h8001_7FFE;
    data_i = 16'h8001;
    data_mod_i = 4'd0;
    data_val_i = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_val%0d", k), 32'(ser_data_val_o), 1);
      chk($sformatf("b2b_dat%0d", k), 32'(ser_data_o), 32'(pair[31-k]));
      chk($sformatf("b2b_busy%0d", k), 32'(busy_o), 32'(k != 15 && k != 31));
      if (k == 15) data_i = 16'h7FFE;
      if (k == 31) data_val_i = 1'b0;
    end
    @(negedge clk);
    idle_chk("b2b_end");

    data_i = 16'h1234;
    data_val_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      data_val_i = 1'b0;
      if (k == 3) begin
        data_i = 16'hFFFF;
        data_val_i = 1'b1;
      end
      chk($sformatf("drop_dat%0d", k), 32'(ser_data_o), 32'(16'h1234 >> (15 - k)) & 1);
      chk($sformatf("drop_val%0d", k), 32'(ser_data_val_o), 1);
    end
    data_val_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_chk($sformatf("drop_end%0d", k));
    end

    data_i = 16'hA5C3;
    data_val_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      data_val_i = 1'b0;
      chk($sformatf("mid_dat%0d", k), 32'(ser_data_o), 32'(data_i[15-k]));
    end
    #2 arst_i = 1'b1;
    #1 idle_chk("mid_async");
    @(negedge clk);
    arst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_chk($sformatf("mid_rel%0d", k));
    end

    lb_on = 1'b1;
    data_mod_i = 4'd0;
    data_i = 16'($urandom);
    tx_q.push_back(data_i);
    data_val_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      t = 0;
      while (busy_o && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (t >= 40) chk("lb_timeout", 32'(t), 0);
      if (i < 99) begin
        data_i = 16'($urandom);
        tx_q.push_back(data_i);
      end else data_val_i = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("lb_count", 32'(rx_q.size()), 100);
    for (int i = 0; i < 100 && i < rx_q.size(); i++)
      chk($sformatf("lb_word%0d", i), 32'(rx_q[i]), 32'(tx_q[i]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
